// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the data_mem arbiter: bus widths, lock-state encodings and lock/perf defaults.
package mem_arbiter_pkg;

  localparam int MEM_ADDR_WIDTH   = 10;
  localparam int MEM_WORD_WIDTH   = 32;
  localparam int MEM_ARB_MAX_LOCK = 8;
  localparam int MEM_ARB_PERF_W   = 16;

  localparam logic [0:0] ARB_ST_ARB    = 1'b0;
  localparam logic [0:0] ARB_ST_LOCKED = 1'b1;

  // Lock counter must be able to hold the value MAX itself.
  function automatic int lock_cnt_width(input int max_beats);
    return (max_beats < 1) ? 1 : $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// One requester port of the data_mem arbiter: valid/ready request plus single-cycle read response.
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_WIDTH,
  parameter int DATA_W = MEM_WORD_WIDTH
);
  logic              valid;
  logic              ready;
  logic              write;
  logic              lock;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;

  modport master (output valid, write, lock, addr, wdata, input ready, rsp_valid, rsp_data);
  modport slave  (input valid, write, lock, addr, wdata, output ready, rsp_valid, rsp_data);
endinterface

// File: rtl/mem_arbiter_rr_grant2.sv
// Combinational 2-way round-robin picker: one-hot grant among masked valids, tie goes away from last_grant.
module mem_arbiter_rr_grant2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  input  logic [1:0] mask,
  output logic [1:0] grant
);
  logic [1:0] eligible;

  always_comb begin
    eligible = valid & mask;
    grant    = eligible;
    if (eligible == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing data_mem between CPU (req0) and loader (req1), with bounded lock bursts.
// Define MEM_ARB_PERF_EN to add saturating grant/conflict counters.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = MEM_ADDR_WIDTH,
  parameter int DATA_W         = MEM_WORD_WIDTH,
  parameter int MAX_LOCK_BEATS = MEM_ARB_MAX_LOCK
`ifdef MEM_ARB_PERF_EN
  ,
  parameter int PERF_W         = MEM_ARB_PERF_W
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_enable,
  mem_arbiter_if.slave      req0,
  mem_arbiter_if.slave      req1,
  output logic [ADDR_W-1:0] o_mem_read_address,
  output logic [ADDR_W-1:0] o_mem_write_address,
  output logic [DATA_W-1:0] o_mem_write_data,
  output logic              o_mem_write_enable,
  input  logic [DATA_W-1:0] i_mem_read_data
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [PERF_W-1:0] o_grant0_count,
  output logic [PERF_W-1:0] o_grant1_count,
  output logic [PERF_W-1:0] o_conflict_count
`endif
);
  localparam int CNT_W = lock_cnt_width(MAX_LOCK_BEATS);

  logic [0:0]       state;
  logic             last_grant;
  logic [CNT_W-1:0] lock_cnt;
  logic [1:0]       rsp_vld;

  logic [1:0]       valid;
  logic [1:0]       mask;
  logic [1:0]       grant;
  logic [1:0]       xfer;
  logic             active;
  logic             any_xfer;
  logic             sel;
  logic             sel_write;
  logic             sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [CNT_W-1:0] next_cnt;
  logic             stay_locked;

  assign valid = {req1.valid, req0.valid};

  // While locked the holder is always last_grant, since only it can transfer.
  assign mask = (state == ARB_ST_LOCKED) ? (last_grant ? 2'b10 : 2'b01) : 2'b11;

  mem_arbiter_rr_grant2 u_pick (
    .valid      (valid),
    .last_grant (last_grant),
    .mask       (mask),
    .grant      (grant)
  );

  assign active   = clk_enable & ~reset;
  assign xfer     = grant & {2{active}};
  assign any_xfer = |xfer;

  assign req0.ready = xfer[0];
  assign req1.ready = xfer[1];

  assign sel       = grant[1];
  assign sel_write = sel ? req1.write : req0.write;
  assign sel_lock  = sel ? req1.lock  : req0.lock;
  assign sel_addr  = sel ? req1.addr  : req0.addr;
  assign sel_wdata = sel ? req1.wdata : req0.wdata;

  assign o_mem_read_address  = sel_addr;
  assign o_mem_write_address = sel_addr;
  assign o_mem_write_data    = sel_wdata;
  assign o_mem_write_enable  = any_xfer & sel_write;

  // data_mem is registered, so read data lines up with the cycle after the address.
  assign req0.rsp_valid = rsp_vld[0];
  assign req1.rsp_valid = rsp_vld[1];
  assign req0.rsp_data  = i_mem_read_data;
  assign req1.rsp_data  = i_mem_read_data;

  assign next_cnt    = (state == ARB_ST_LOCKED) ? lock_cnt + CNT_W'(1) : CNT_W'(1);
  assign stay_locked = sel_lock & (next_cnt < CNT_W'(MAX_LOCK_BEATS));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ARB_ST_ARB;
      last_grant <= 1'b1;
      lock_cnt   <= '0;
      rsp_vld    <= 2'b00;
    end else if (clk_enable) begin
      rsp_vld <= xfer & ~{req1.write, req0.write};
      if (any_xfer) begin
        last_grant <= sel;
        if (stay_locked) begin
          state    <= ARB_ST_LOCKED;
          lock_cnt <= next_cnt;
        end else begin
          state    <= ARB_ST_ARB;
          lock_cnt <= '0;
        end
      end
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_grant0_count   <= '0;
      o_grant1_count   <= '0;
      o_conflict_count <= '0;
    end else if (clk_enable) begin
      if (xfer[0] && (o_grant0_count != '1)) o_grant0_count <= o_grant0_count + PERF_W'(1);
      if (xfer[1] && (o_grant1_count != '1)) o_grant1_count <= o_grant1_count + PERF_W'(1);
      // Both valid means exactly one loses, whether by tie-break or by lock.
      if ((&valid) && (o_conflict_count != '1)) o_conflict_count <= o_conflict_count + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter: read data expectations queue per requester, grants checked inline.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW = MEM_ADDR_WIDTH;
  localparam int DW = MEM_WORD_WIDTH;

  logic          clk;
  logic          reset;
  logic          clk_enable;
  logic [AW-1:0] mem_raddr;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
  logic [15:0]   g0_cnt;
  logic [15:0]   g1_cnt;
  logic [15:0]   cf_cnt;
`endif

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) r0 ();
  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) r1 ();

  mem_arbiter dut (
    .clk                 (clk),
    .reset               (reset),
    .clk_enable          (clk_enable),
    .req0                (r0.slave),
    .req1                (r1.slave),
    .o_mem_read_address  (mem_raddr),
    .o_mem_write_address (mem_waddr),
    .o_mem_write_data    (mem_wdata),
    .o_mem_write_enable  (mem_we),
    .i_mem_read_data     (mem_rdata)
`ifdef MEM_ARB_PERF_EN
    ,
    .o_grant0_count      (g0_cnt),
    .o_grant1_count      (g1_cnt),
    .o_conflict_count    (cf_cnt)
`endif
  );

  logic [DW-1:0] mem     [1024];
  logic [DW-1:0] ref_mem [1024];
  logic [DW-1:0] exp0 [$];
  logic [DW-1:0] exp1 [$];
  int tests_run    = 0;
  int tests_failed = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read memory stub, frozen by the global stall like the real data_mem.
  always @(posedge clk) begin
    if (clk_enable) begin
      if (mem_we) mem[mem_waddr] <= mem_wdata;
      mem_rdata <= mem[mem_raddr];
    end
  end

  // Response monitor: each enabled cycle with rsp_valid consumes one expected word.
  always @(negedge clk) begin
    if (!reset && clk_enable) begin
      if (r0.rsp_valid) begin
        tests_run++;
        if (exp0.size() == 0) begin
          tests_failed++;
          $display("FAIL rsp0_unexpected: got data %0h, none expected", r0.rsp_data);
        end else begin
          logic [DW-1:0] e;
          e = exp0.pop_front();
          if (r0.rsp_data !== e) begin
            tests_failed++;
            $display("FAIL rsp0_data: got %0h exp %0h", r0.rsp_data, e);
          end
        end
      end
      if (r1.rsp_valid) begin
        tests_run++;
        if (exp1.size() == 0) begin
          tests_failed++;
          $display("FAIL rsp1_unexpected: got data %0h, none expected", r1.rsp_data);
        end else begin
          logic [DW-1:0] e;
          e = exp1.pop_front();
          if (r1.rsp_data !== e) begin
            tests_failed++;
            $display("FAIL rsp1_data: got %0h exp %0h", r1.rsp_data, e);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    r0.valid = 1'b0; r0.write = 1'b0; r0.lock = 1'b0;
    r1.valid = 1'b0; r1.write = 1'b0; r1.lock = 1'b0;
  endtask

  task automatic check_ready(input string name, input logic e0, input logic e1);
    tests_run++;
    if (r0.ready !== e0 || r1.ready !== e1) begin
      tests_failed++;
      $display("FAIL %s: ready got %b%b exp %b%b", name, r1.ready, r0.ready, e1, e0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    r0.valid = 1'b1; r1.valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_ready("reset_ready", 1'b0, 1'b0);
    tests_run++;
    if (mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_we: got %b exp 0", mem_we);
    end
    tests_run++;
    if (r0.rsp_valid !== 1'b0 || r1.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_rsp: got %b%b exp 00", r1.rsp_valid, r0.rsp_valid);
    end
`ifdef MEM_ARB_PERF_EN
    tests_run++;
    if (g0_cnt !== 16'd0 || g1_cnt !== 16'd0 || cf_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_perf: got %0d %0d %0d exp 0 0 0", g0_cnt, g1_cnt, cf_cnt);
    end
`endif
    next_cycle();
    reset = 1'b0;
    idle_all();
    next_cycle();
  endtask

  task automatic test_first_grant();
    r0.valid = 1'b1; r0.addr = 10'h010;
    r1.valid = 1'b1; r1.addr = 10'h020;
    @(negedge clk);
    check_ready("first_tie", 1'b1, 1'b0);
    tests_run++;
    if (mem_raddr !== 10'h010) begin
      tests_failed++;
      $display("FAIL first_addr: got %0h exp 10", mem_raddr);
    end
    exp0.push_back(ref_mem[10'h010]);
    next_cycle();
    r0.valid = 1'b0;
    @(negedge clk);
    check_ready("first_second", 1'b0, 1'b1);
    tests_run++;
    if (r0.rsp_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_rsp0_valid: got %b exp 1", r0.rsp_valid);
    end
    exp1.push_back(ref_mem[10'h020]);
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_alternate();
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    a0 = 10'h030; a1 = 10'h040;
    for (int i = 0; i < 6; i++) begin
      r0.valid = 1'b1; r0.addr = a0;
      r1.valid = 1'b1; r1.addr = a1;
      @(negedge clk);
      check_ready("alternate", (i % 2) == 0, (i % 2) == 1);
      if ((i % 2) == 0) begin
        exp0.push_back(ref_mem[a0]);
        a0 = a0 + 10'd1;
      end else begin
        exp1.push_back(ref_mem[a1]);
        a1 = a1 + 10'd1;
      end
      next_cycle();
    end
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_write_read();
    r1.valid = 1'b1; r1.write = 1'b1; r1.addr = 10'h005; r1.wdata = 32'hDEADBEEF;
    @(negedge clk);
    check_ready("wr_grant", 1'b0, 1'b1);
    tests_run++;
    if (mem_we !== 1'b1 || mem_waddr !== 10'h005 || mem_wdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("FAIL wr_bus: got we=%b a=%0h d=%0h exp we=1 a=5 d=deadbeef", mem_we, mem_waddr, mem_wdata);
    end
    ref_mem[10'h005] = 32'hDEADBEEF;
    next_cycle();
    idle_all();
    r0.valid = 1'b1; r0.addr = 10'h005;
    @(negedge clk);
    check_ready("rd_after_wr", 1'b1, 1'b0);
    tests_run++;
    if (mem_we !== 1'b0 || r1.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_after_wr_we: got we=%b rsp1=%b exp 0 0", mem_we, r1.rsp_valid);
    end
    exp0.push_back(ref_mem[10'h005]);
    next_cycle();
    idle_all();
    @(negedge clk);
    tests_run++;
    if (mem_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_single_pulse: got we=%b exp 0", mem_we);
    end
    next_cycle();
  endtask

  task automatic test_lock_burst();
    int n0;
    logic e0;
    logic e1;
    // Prime last_grant=1 so req0 wins the opening tie.
    r1.valid = 1'b1; r1.addr = 10'h050;
    @(negedge clk);
    check_ready("lock_prime", 1'b0, 1'b1);
    exp1.push_back(ref_mem[10'h050]);
    next_cycle();
    n0 = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      r0.valid = (cyc != 3); r0.lock = 1'b1; r0.addr = 10'h100 + AW'(cyc);
      r1.valid = 1'b1; r1.lock = 1'b0; r1.addr = 10'h200;
      e0 = (cyc != 3) && (n0 < MEM_ARB_MAX_LOCK);
      e1 = (n0 >= MEM_ARB_MAX_LOCK);
      @(negedge clk);
      check_ready("lock_burst", e0, e1);
      if (e0) begin
        exp0.push_back(ref_mem[10'h100 + AW'(cyc)]);
        n0++;
      end
      if (e1) exp1.push_back(ref_mem[10'h200]);
      next_cycle();
    end
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_stall();
    r1.valid = 1'b1; r1.addr = 10'h061;
    @(negedge clk);
    check_ready("stall_pre", 1'b0, 1'b1);
    exp1.push_back(ref_mem[10'h061]);
    next_cycle();
    clk_enable = 1'b0;
    r0.valid = 1'b1; r0.addr = 10'h060;
    r1.valid = 1'b1; r1.addr = 10'h062;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_ready("stall_ready", 1'b0, 1'b0);
      tests_run++;
      if (mem_we !== 1'b0 || r1.rsp_valid !== 1'b1) begin
        tests_failed++;
        $display("FAIL stall_hold: got we=%b rsp1=%b exp we=0 rsp1=1", mem_we, r1.rsp_valid);
      end
      next_cycle();
    end
    clk_enable = 1'b1;
    @(negedge clk);
    check_ready("stall_resume", 1'b1, 1'b0);
    exp0.push_back(ref_mem[10'h060]);
    next_cycle();
    r0.valid = 1'b0;
    @(negedge clk);
    check_ready("stall_next", 1'b0, 1'b1);
    exp1.push_back(ref_mem[10'h062]);
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  task automatic test_reset_mid();
    r0.valid = 1'b1; r0.addr = 10'h070;
    @(negedge clk);
    check_ready("rstmid_xfer0", 1'b1, 1'b0);
    next_cycle();
    reset = 1'b1;
    idle_all();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests_run++;
      if (r0.rsp_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_rsp0: got %b exp 0", r0.rsp_valid);
      end
      next_cycle();
      reset = 1'b0;
    end
`ifdef MEM_ARB_PERF_EN
    tests_run++;
    if (g0_cnt !== 16'd0 || g1_cnt !== 16'd0 || cf_cnt !== 16'd0) begin
      tests_failed++;
      $display("FAIL rstmid_perf: got %0d %0d %0d exp 0 0 0", g0_cnt, g1_cnt, cf_cnt);
    end
`endif
    // Take a lock on req1, reset mid-burst, then a tie must go to req0.
    r1.valid = 1'b1; r1.lock = 1'b1; r1.addr = 10'h071;
    @(negedge clk);
    check_ready("rstmid_lock1", 1'b0, 1'b1);
    next_cycle();
    reset = 1'b1;
    idle_all();
    @(negedge clk);
    tests_run++;
    if (r1.rsp_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_rsp1: got %b exp 0", r1.rsp_valid);
    end
    next_cycle();
    reset = 1'b0;
    r0.valid = 1'b1; r0.addr = 10'h072;
    r1.valid = 1'b1; r1.lock = 1'b1; r1.addr = 10'h073;
    @(negedge clk);
    check_ready("rstmid_unlocked", 1'b1, 1'b0);
    exp0.push_back(ref_mem[10'h072]);
    next_cycle();
    idle_all();
    next_cycle();
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'hA500_0000 + i;
      ref_mem[i] = 32'hA500_0000 + i;
    end
    mem_rdata  = '0;
    reset      = 1'b1;
    clk_enable = 1'b1;
    r0.addr = '0; r0.wdata = '0;
    r1.addr = '0; r1.wdata = '0;
    idle_all();

    test_reset();
    test_first_grant();
    test_alternate();
    test_write_read();
    test_lock_burst();
    test_stall();
    test_reset_mid();

    tests_run++;
    if (exp0.size() != 0 || exp1.size() != 0) begin
      tests_failed++;
      $display("FAIL rsp_missing: outstanding %0d/%0d exp 0/0", exp0.size(), exp1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-port round-robin arbiter that shares the single data_mem between requester 0 (CPU data port) and requester 1 (loader/DMA port).
- Sits between pipelined_cpu / loader and data_mem in the top level.
- Valid/ready request handshake per requester; one-cycle read response per requester.
- Optional lock lets one requester hold the memory for a bounded burst.

Parameters:
ADDR_W, `MEM_ADDR_WIDTH, memory address width
DATA_W, `MEM_WORD_WIDTH, memory word width
MAX_LOCK_BEATS, 8, max consecutive locked transfers before forced release (>=1)
PERF_W, 16, width of optional performance counters

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
clk_enable  in  1  global stall; low freezes all state
req0_valid / req1_valid  in  1  request present
req0_ready / req1_ready  out  1  request accepted this cycle
req0_write / req1_write  in  1  1=write, 0=read
req0_lock / req1_lock  in  1  keep grant after this beat
req0_addr / req1_addr  in  ADDR_W  word address
req0_wdata / req1_wdata  in  DATA_W  write data
rsp0_valid / rsp1_valid  out  1  read data valid
rsp0_data / rsp1_data  out  DATA_W  read data
o_mem_read_address  out  ADDR_W  to data_mem r_address
o_mem_write_address  out  ADDR_W  to data_mem w_address
o_mem_write_data  out  DATA_W  to data_mem w_data
o_mem_write_enable  out  1  to data_mem w_enable
i_mem_read_data  in  DATA_W  from data_mem o_data (valid 1 cycle after address)

Behaviour:
- Reset (async, active-high): state=ARB, last_grant=1 (requester 0 wins first tie), lock_cnt=0, rsp*_valid=0, all readies 0, o_mem_write_enable=0. Memory address/data outputs are don't-care during reset.
- Transfer = reqN_valid & reqN_ready. At most one transfer per cycle.
- ARB state grant:
  - Only one requester valid: that requester is granted.
  - Both valid: the requester that is not last_grant is granted.
- LOCKED state: only the lock holder may be granted. The other requester's ready is held at 0 even if the holder is idle.
- reqN_ready = grantN & clk_enable. Ready is combinational from valid, state and last_grant.
- Granted request drives o_mem_read_address and o_mem_write_address with reqN_addr in the same cycle.
- Write transfer: o_mem_write_enable=1 and o_mem_write_data=reqN_wdata in the same cycle. No response is returned.
- Read transfer: o_mem_write_enable=0. On the next enabled cycle, rspN_valid=1 for exactly one cycle and rspN_data=i_mem_read_data. Back-to-back reads give back-to-back responses.
- last_grant updates to N on every transfer. No update when there is no transfer.
- Lock handling:
  - Transfer with reqN_lock=1 in ARB: state->LOCKED(holder=N), lock_cnt=1.
  - Each further holder transfer increments lock_cnt.
  - Holder transfer with lock=0: state->ARB.
  - If lock_cnt reaches MAX_LOCK_BEATS on a transfer, state->ARB regardless of lock. The other requester then wins the next tie through last_grant.
- clk_enable=0: no state, pointer, counter or response change. All readies=0, o_mem_write_enable=0, rsp*_valid hold their values.
- Reset asserted mid-burst or with a read outstanding: lock and pending response are dropped, and no rsp pulse follows.
- Simultaneous valid with identical addresses: no special handling; arbitration order defines the result.

Optional Feature:
MEM_ARB_PERF_EN
- Defined: adds outputs o_grant0_count, o_grant1_count and o_conflict_count (PERF_W each, reset 0).
  - o_grant0_count / o_grant1_count increment on each transfer of requester 0 / 1.
  - o_conflict_count increments on any enabled cycle where both valids are high and one requester is not granted.
  - All counters saturate at all-ones.
- Not defined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package (constants.vh): ARB_ST_ARB/ARB_ST_LOCKED state encodings, MEM_ARB_MAX_LOCK default. Reuse existing MEM_ADDR_WIDTH/MEM_WORD_WIDTH.
- One natural sub-module, rr_grant2: pure combinational 2-way round-robin picker taking valids, last_grant and lock mask, returning the one-hot grant.
- Lock FSM, response tracking and perf counters stay in mem_arbiter.

Test Plan:
- After reset, req0 read addr 0x10 and req1 read addr 0x20 both valid -> req0_ready=1 first cycle. rsp0_valid next cycle with mem[0x10]. req1 granted the following cycle.
- Both requesters continuously valid for 6 cycles, no lock -> grants alternate 0,1,0,1,0,1.
- req1 write addr 0x05 data 0xDEADBEEF, then req0 read 0x05 -> o_mem_write_enable pulses once. rsp0_data=0xDEADBEEF.
- req0 holds lock=1 with req1 valid throughout, MAX_LOCK_BEATS=8 -> exactly 8 req0 transfers, then req1 granted.
- clk_enable=0 for 3 cycles during a read request -> no readies, no write enable, last_grant unchanged. Transfer completes on re-enable.
- Reset pulsed the cycle after a req0 read transfer -> rsp0_valid stays 0. With MEM_ARB_PERF_EN, all counters read 0.
